gpr_dbg_access: RTL

- Host-side debug access port for the NPC integer register file. The simulator issues single-register read or write requests through a valid/ready handshake.
- The block halts the core, performs the access on a dedicated regfile debug port, and returns a response through a second valid/ready handshake.
- It is the inbound counterpart of the register-state export path: the host pushes and pulls GPR values instead of only observing them.
- Sits between the DPI-driven debug shim and the regfile.

---
 rtl/gpr_dbg_access.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/gpr_dbg_access.sv
// Host-side debug access port for the integer register file.
// A host request halts the core, performs one read or write on the
// dedicated regfile debug port, then returns a single response.
// halt_req is held until the response handshake so the core cannot
// retire between the access and the host seeing its result.
module gpr_dbg_access #(
    parameter int NUM_REGS     = 32,
    parameter int XLEN         = 64,
    parameter int HALT_TIMEOUT = 255
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [5:0]      req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err,
    output logic            halt_req,
    input  logic            halted,
    output logic [4:0]      rf_addr,
    input  logic [XLEN-1:0] rf_rdata,
    output logic            rf_wen,
    output logic [XLEN-1:0] rf_wdata
);

    typedef enum logic [1:0] {
        IDLE,
        HALT_WAIT,
        ACCESS,
        RESP
    } state_t;

    localparam logic [31:0] NUM_REGS_U   = 32'(NUM_REGS);
    localparam logic [15:0] TIMEOUT_LAST = 16'(HALT_TIMEOUT - 1);

    state_t            state_reg, state_next;
    logic              write_reg, write_next;
    logic [5:0]        addr_reg, addr_next;
    logic [XLEN-1:0]   wdata_reg, wdata_next;
    logic [15:0]       cnt_reg, cnt_next;
    logic [XLEN-1:0]   rdata_reg, rdata_next;
    logic              err_reg, err_next;
    logic              halt_reg, halt_next;

    logic              accept;
    logic              addr_bad;
    logic              access_en;
    logic              addr_zero;

    // Reset masks every output so nothing leaks out on the reset cycle,
    // including a write strobe from an interrupted ACCESS.
    assign req_ready  = (state_reg == IDLE) && !reset;
    assign accept     = req_valid && req_ready;
    assign addr_bad   = ({26'd0, req_addr} >= NUM_REGS_U);
    assign access_en  = (state_reg == ACCESS) && !reset;
    assign addr_zero  = (addr_reg == 6'd0);

    assign resp_valid = (state_reg == RESP) && !reset;
    assign resp_rdata = reset ? '0 : rdata_reg;
    assign resp_err   = err_reg && !reset;
    assign halt_req   = halt_reg && !reset;

    // x0 is hardwired: writes to it are dropped, and the strobe is also
    // gated by halted so the core and the debug port never write together.
    assign rf_addr    = access_en ? addr_reg[4:0] : 5'd0;
    assign rf_wen     = access_en && write_reg && !addr_zero && halted;
    assign rf_wdata   = rf_wen ? wdata_reg : '0;

    // Next-state and datapath for the request/halt/access/response sequence.
    always_comb begin
        state_next = state_reg;
        write_next = write_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        cnt_next   = cnt_reg;
        rdata_next = rdata_reg;
        err_next   = err_reg;
        halt_next  = halt_reg;

        unique case (state_reg)
            IDLE: begin
                if (accept) begin
                    write_next = req_write;
                    addr_next  = req_addr;
                    wdata_next = req_wdata;
                    rdata_next = '0;
                    if (addr_bad) begin
                        state_next = RESP;
                        err_next   = 1'b1;
                        halt_next  = 1'b0;
                    end else begin
                        state_next = HALT_WAIT;
                        err_next   = 1'b0;
                        halt_next  = 1'b1;
                        cnt_next   = 16'd0;
                    end
                end
            end
            HALT_WAIT: begin
                if (halted) begin
                    state_next = ACCESS;
                end else if (cnt_reg == TIMEOUT_LAST) begin
                    // Core never halted: abort without touching the regfile
                    // and release the halt request.
                    state_next = RESP;
                    err_next   = 1'b1;
                    rdata_next = '0;
                    halt_next  = 1'b0;
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            ACCESS: begin
                state_next = RESP;
                err_next   = 1'b0;
                rdata_next = (!write_reg && !addr_zero) ? rf_rdata : '0;
            end
            RESP: begin
                if (resp_ready) begin
                    state_next = IDLE;
                    halt_next  = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= IDLE;
            write_reg <= 1'b0;
            addr_reg  <= 6'd0;
            wdata_reg <= '0;
            cnt_reg   <= 16'd0;
            rdata_reg <= '0;
            err_reg   <= 1'b0;
            halt_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            write_reg <= write_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            cnt_reg   <= cnt_next;
            rdata_reg <= rdata_next;
            err_reg   <= err_next;
            halt_reg  <= halt_next;
        end
    end

endmodule
